// File: rtl/ula_flag_wb.sv
// Execute/writeback stage behind the ULA: computes Z/N/C/V, holds the flag register and
// buffers results in a 2-entry FIFO for the register file. Define ULA_WB_BYPASS_EN for a zero-latency empty-FIFO bypass.
module ula_flag_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] Out,
  input  logic [ADDR_W-1:0] dest,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [3:0]        flags,
  output logic              Flag
);

  localparam int ENT_W = DATA_W + ADDR_W;

  // Returns {update, Z, N, C, V}; update=0 for unused opcodes so the flag register holds.
  function automatic logic [4:0] calc_flags(input logic [4:0]        op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] res);
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              cin;
    logic              arith;
    logic              upd;
    logic [DATA_W:0]   s;
    logic              c;
    logic              v;
    x     = a;
    y     = b;
    cin   = 1'b0;
    arith = 1'b1;
    upd   = 1'b1;
    case (op)
      5'b00000: begin y = b;               cin = 1'b0; end
      5'b00001: begin y = b;               cin = 1'b1; end
      5'b00011: begin y = '0;              cin = 1'b1; end
      5'b00100: begin y = ~b;              cin = 1'b0; end
      5'b00101: begin y = ~b;              cin = 1'b1; end
      5'b00110: begin y = '1;              cin = 1'b0; end
      5'b01000, 5'b01001: arith = 1'b0;
      default: begin
        arith = 1'b0;
        upd   = op[4];
      end
    endcase
    s = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
    c = arith & s[DATA_W];
    v = arith & (x[DATA_W-1] == y[DATA_W-1]) & (s[DATA_W-1] != x[DATA_W-1]);
    return {upd, (res == '0), res[DATA_W-1], c, v};
  endfunction

  logic [ENT_W-1:0] mem_p0 [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [3:0]       flag_reg;
  logic             fifo_vld;
  logic             accept;
  logic             push;
  logic             pop;
  logic [4:0]       new_flags;
  logic [ENT_W-1:0] head;

  assign fifo_vld  = (count != 2'd0);
  assign head      = mem_p0[rd_ptr];
  assign pop       = fifo_vld && wb_ready;
  assign in_ready  = (count < 2'd2) || (wb_valid && wb_ready);
  assign accept    = in_valid && in_ready;
  assign new_flags = calc_flags(opcode, A, B, Out);

`ifdef ULA_WB_BYPASS_EN
  logic byp;
  // An empty FIFO lets the incoming result through combinationally; it is only
  // buffered when the register file cannot take it this cycle.
  assign byp      = !fifo_vld && in_valid;
  assign wb_valid = fifo_vld || byp;
  assign wb_data  = byp ? Out  : head[DATA_W-1:0];
  assign wb_addr  = byp ? dest : head[ENT_W-1:DATA_W];
  assign push     = accept && !(byp && wb_ready);
`else
  assign wb_valid = fifo_vld;
  assign wb_data  = head[DATA_W-1:0];
  assign wb_addr  = head[ENT_W-1:DATA_W];
  assign push     = accept;
`endif

  assign flags = flag_reg;
  assign Flag  = flag_reg[3];

  // Stage p0: FIFO storage, pointers and the architectural flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      flag_reg  <= 4'b0000;
      mem_p0[0] <= '0;
      mem_p0[1] <= '0;
    end else begin
      if (push) begin
        mem_p0[wr_ptr] <= {dest, Out};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && new_flags[4]) flag_reg <= new_flags[3:0];
    end
  end

endmodule

// File: tb/tb_ula_flag_wb.sv
// Directed bench for ula_flag_wb: table of flag vectors plus hand-written
// backpressure, full push/pop, unused-opcode and reset-flush sequences.
module tb_ula_flag_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B, Out;
  logic [4:0]  opcode;
  logic [3:0]  dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_addr;
  logic [3:0]  flags;
  logic        Flag;

  int pass_cnt = 0;
  int total_cnt = 0;

  ula_flag_wb #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .Out(Out), .dest(dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .flags(flags), .Flag(Flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  dst;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] dst);
    opcode = op; A = a; B = b; Out = res; dest = dst;
  endtask

  initial begin
    // {opcode, A, B, Out, dest, expected {Z,N,C,V}}
    vecs[0]  = '{5'b00101, 32'd5,        32'd5, 32'h0,        4'd1, 4'b1010};
    vecs[1]  = '{5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'd2, 4'b0101};
    vecs[2]  = '{5'b00000, 32'hFFFFFFFF, 32'd1, 32'h0,        4'd3, 4'b1010};
    vecs[3]  = '{5'b00101, 32'd3,        32'd5, 32'hFFFFFFFE, 4'd4, 4'b0100};
    vecs[4]  = '{5'b00101, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'd5, 4'b0011};
    vecs[5]  = '{5'b00011, 32'hFFFFFFFF, 32'd0, 32'h0,        4'd6, 4'b1010};
    vecs[6]  = '{5'b00110, 32'h0,        32'd0, 32'hFFFFFFFF, 4'd7, 4'b0100};
    vecs[7]  = '{5'b00001, 32'd1,        32'd2, 32'd4,        4'd8, 4'b0000};
    vecs[8]  = '{5'b00100, 32'd10,       32'd3, 32'd6,        4'd9, 4'b0010};
    vecs[9]  = '{5'b01000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 4'd10, 4'b0100};
    vecs[10] = '{5'b10011, 32'h7FFFFFFF, 32'd1, 32'h0,        4'd11, 4'b1000};
    vecs[11] = '{5'b00111, 32'd0,        32'd0, 32'h1234,     4'd12, 4'b1000};
    vecs[12] = '{5'b01010, 32'd0,        32'd0, 32'h0,        4'd13, 4'b1000};
    vecs[13] = '{5'b01001, 32'h1,        32'd1, 32'h8,        4'd14, 4'b0000};

    reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
    drive(5'b00000, 32'd0, 32'd0, 32'd0, 4'd0);

    // Reset state
    step(); step();
    reset = 1'b0;
    #1;
    check("reset_flags", {28'd0, flags}, 32'h0);
    check("reset_wb_valid", {31'd0, wb_valid}, 32'h0);
    check("reset_wb_data", wb_data, 32'h0);
    check("reset_wb_addr", {28'd0, wb_addr}, 32'h0);
    check("reset_in_ready", {31'd0, in_ready}, 32'h1);

    // Flag table: accept, then see flags and the buffered write one cycle later
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dst);
      in_valid = 1'b1; wb_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].exp_flags});
      check($sformatf("vec%0d_Flag", i), {31'd0, Flag}, {31'd0, vecs[i].exp_flags[3]});
      check($sformatf("vec%0d_wb_valid", i), {31'd0, wb_valid}, 32'h1);
      check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].res);
      check($sformatf("vec%0d_wb_addr", i), {28'd0, wb_addr}, {28'd0, vecs[i].dst});
      step();
      check($sformatf("vec%0d_drained", i), {31'd0, wb_valid}, 32'h0);
    end

    // Backpressure: three back-to-back entries with the register file stalled
    wb_ready = 1'b0;
    drive(5'b00000, 32'd1, 32'd1, 32'd2, 4'd1);  // flags 0000
    in_valid = 1'b1;
    step();
    drive(5'b00101, 32'd5, 32'd5, 32'd0, 4'd2);  // flags 1010
    step();
    drive(5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'd3);  // flags 0101
    #1;
    check("bp_in_ready_full", {31'd0, in_ready}, 32'h0);
    step();
    check("bp_flags_entry2", {28'd0, flags}, 32'ha);
    check("bp_head_stable", {28'd0, wb_addr}, 32'h1);
    check("bp_head_data", wb_data, 32'd2);
    // Full with simultaneous pop and push
    wb_ready = 1'b1;
    #1;
    check("full_in_ready_pop", {31'd0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    wb_ready = 1'b0;
    #1;
    check("full_count_stays2", {31'd0, in_ready}, 32'h0);
    check("order_2_addr", {28'd0, wb_addr}, 32'h2);
    check("order_2_data", wb_data, 32'h0);
    check("flags_entry3", {28'd0, flags}, 32'h5);
    wb_ready = 1'b1;
    step();
    check("order_3_addr", {28'd0, wb_addr}, 32'h3);
    check("order_3_data", wb_data, 32'h80000000);
    step();
    check("order_empty", {31'd0, wb_valid}, 32'h0);

    // Unused opcode leaves flags=1010 but still writes back
    drive(5'b00101, 32'd7, 32'd7, 32'd0, 4'd4);
    in_valid = 1'b1;
    step();
    drive(5'b00111, 32'd1, 32'd2, 32'hCAFE0001, 4'd5);
    step();
    in_valid = 1'b0;
    check("unused_flags", {28'd0, flags}, 32'ha);
    check("unused_wb_data", wb_data, 32'hCAFE0001);
    check("unused_wb_addr", {28'd0, wb_addr}, 32'h5);
    step();

    // Reset while two entries are buffered flushes them
    wb_ready = 1'b0;
    drive(5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'd6);
    in_valid = 1'b1;
    step();
    drive(5'b00000, 32'd1, 32'd1, 32'd2, 4'd7);
    step();
    in_valid = 1'b0;
    check("pre_reset_valid", {31'd0, wb_valid}, 32'h1);
    reset = 1'b1;
    step();
    check("midreset_wb_valid", {31'd0, wb_valid}, 32'h0);
    check("midreset_flags", {28'd0, flags}, 32'h0);
    check("midreset_wb_data", wb_data, 32'h0);
    reset = 1'b0;
    wb_ready = 1'b1;
    step();
    check("post_reset_valid", {31'd0, wb_valid}, 32'h0);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ula_flag_wb.md
Name: ula_flag_wb

Overview:
- Execute/writeback stage directly downstream of the ULA.
- Accepts the ULA result together with its operands, opcode and destination register.
- Computes the condition flags Z, N, C and V, and holds them in an architectural flag register.
- Buffers results in a 2-entry FIFO and delivers them to the register file through a valid/ready handshake, so the ULA issue side is never blocked by register-file contention.

Parameters:
- DATA_W, 32, operand and result width.
- ADDR_W, 4, destination register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers an ALU result this cycle.
- in_ready  out  1  stage can accept this cycle.
- A  in  DATA_W  ULA operand A, same value the ULA saw.
- B  in  DATA_W  ULA operand B.
- opcode  in  5  ULA opcode.
- Out  in  DATA_W  ULA result.
- dest  in  ADDR_W  destination register index.
- wb_valid  out  1  writeback entry available.
- wb_ready  in  1  register file consumes the entry.
- wb_data  out  DATA_W  result to write.
- wb_addr  out  ADDR_W  register to write.
- flags  out  4  architectural {Z,N,C,V}.
- Flag  out  1  equals flags Z bit; kept for the existing zero-test path.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied, flags=4'b0000, wb_valid=0, wb_data=0, wb_addr=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-transfer discards all buffered entries; no write is presented afterwards.
- Acceptance:
  - A transfer occurs when in_valid && in_ready on the clock edge.
  - in_ready = (count<2) || (wb_valid && wb_ready); same-cycle push and pop are allowed when the FIFO is full.
- Output side:
  - Pop occurs when wb_valid && wb_ready.
  - wb_data/wb_addr are driven from the FIFO head register and are stable while wb_valid && !wb_ready.
- Latency: accepted entry visible on wb_valid the cycle after acceptance (1 cycle).
- FIFO:
  - 2 entries; read and write pointers are 1 bit and wrap 1->0; count range 0..2.
  - Push on full without a simultaneous pop cannot occur, because in_ready=0.
  - Pop on empty is ignored.
- Flag computation uses a 33-bit sum S = X + Y + cin:
  - 00000 add: X=A, Y=B, cin=0.
  - 00001 addinc: X=A, Y=B, cin=1.
  - 00011 inca: X=A, Y=0, cin=1.
  - 00100 subdec: X=A, Y=~B, cin=0.
  - 00101 sub: X=A, Y=~B, cin=1.
  - 00110 deca: X=A, Y=32'hFFFFFFFF, cin=0.
  - For these six arithmetic opcodes: C=S[32] (1 = no borrow for subtracts); V=(X[31]==Y[31]) && (S[31]!=X[31]).
  - 01000, 01001 and all 1xxxx opcodes: C=0, V=0.
  - For every valid opcode: Z=(Out==0); N=Out[31].
  - Unused opcodes (00010, 00111, 01010-01111): the result is still buffered and written back, but flags are unchanged.
- Flag update timing:
  - flags update on the acceptance edge, not on pop, so flags follow issue order.
  - Flags update even when wb_ready is held low.

Optional Feature:
- ULA_WB_BYPASS_EN defined:
  - When the FIFO is empty and in_valid=1, the input is passed combinationally: wb_valid=in_valid, wb_data=Out, wb_addr=dest, latency 0.
  - If wb_ready=1 in that cycle, the entry is consumed and not pushed.
  - If wb_ready=0, the entry is pushed normally.
  - Flags are unaffected by the bypass path and still update on the acceptance edge.
- Undefined: latency is always 1 cycle, and wb_* are purely registered.

Test Plan:
- Reset check: hold reset 2 cycles -> flags=0000, wb_valid=0, in_ready=1.
- Sub with A=5, B=5, opcode=00101, Out=0, wb_ready=1 -> flags Z=1 N=0 C=1 V=0 next cycle; wb_data=0 with wb_valid 1 cycle after acceptance.
- Add with A=32'h7FFFFFFF, B=1, opcode=00000, Out=32'h80000000 -> Z=0 N=1 C=0 V=1.
- Backpressure: wb_ready=0, push 3 back-to-back entries (dest 1,2,3) -> in_ready drops after 2 accepted. Then raise wb_ready -> writes emitted in order 1,2,3 with no loss or duplication. Flags reflect entry 2 while the third entry is stalled.
- Full with simultaneous push/pop: FIFO full, wb_ready=1, in_valid=1 -> accepted the same cycle, count stays 2.
- Unused opcode 00111 after flags=1010 -> flags remain 1010, and wb_data still equals Out. Separately, assert reset while the FIFO holds 2 entries -> wb_valid=0 the next cycle.
